// File: rtl/lfsr_rng_param.sv
// lfsr_rng_param: XNOR Fibonacci-LFSR random-number generator with start/busy/done handshake.
// Define LFSR_LOCKUP_FIX_EN to clear bit0 of an all-ones seed (the XNOR lockup state).
module lfsr_rng_param #(
  parameter int WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS = 14'h2015,
  parameter int SHIFTS = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             seed_en,
  input  logic [WIDTH-1:0] seed_in,
  output logic             busy,
  output logic             done_tick,
  output logic [WIDTH-1:0] random_num
);
  localparam int CW = $clog2(SHIFTS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ctr, work, raw, seed, nxt;
  logic [CW-1:0] cnt;
  assign raw = seed_en ? seed_in : ctr;
`ifdef LFSR_LOCKUP_FIX_EN
  assign seed = &raw ? {raw[WIDTH-1:1], 1'b0} : raw;
`else
  assign seed = raw;
`endif
  assign nxt = {work[WIDTH-2:0], ~^(work & TAPS)};
  assign busy = state == SHIFT || state == DONE;
  assign done_tick = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ctr <= '0;
      work <= '0;
      cnt <= '0;
      random_num <= '0;
    end else begin
      ctr <= ctr + 1'b1;
      case (state)
        IDLE: if (start) begin
          work <= seed;
          cnt <= CW'(SHIFTS);
          state <= SHIFT;
        end
        SHIFT: begin
          work <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            random_num <= nxt;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rng_param.sv
// tb_lfsr_rng_param: randomized requests on the default build checked against a bit-counting
// LFSR model, plus directed parameter variants, held start and mid-request reset.
module tb_lfsr_rng_param;
  localparam int W = 14, S = 14;
`ifdef LFSR_LOCKUP_FIX_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif
  logic clk = 0, reset_n = 0, start = 0, seed_en = 0, st2 = 0;
  logic [W-1:0] seed_in = '0, random_num, rn4, rn1;
  logic [3:0] rnw2, rnw1;
  logic busy, done_tick, busy4, done4, busyw2, donew2, busyw1, donew1, busy1, done1;
  int total = 0, bad = 0, cyc = 0;
  int unsigned last = 0;

  lfsr_rng_param dut (.clk(clk), .reset_n(reset_n), .start(start), .seed_en(seed_en),
    .seed_in(seed_in), .busy(busy), .done_tick(done_tick), .random_num(random_num));
  lfsr_rng_param #(.SHIFTS(4)) d4 (.clk(clk), .reset_n(reset_n), .start(st2), .seed_en(1'b1),
    .seed_in(14'h0000), .busy(busy4), .done_tick(done4), .random_num(rn4));
  lfsr_rng_param #(.WIDTH(4), .TAPS(4'b1001), .SHIFTS(2)) dw2 (.clk(clk), .reset_n(reset_n),
    .start(st2), .seed_en(1'b1), .seed_in(4'b0000), .busy(busyw2), .done_tick(donew2), .random_num(rnw2));
  lfsr_rng_param #(.WIDTH(4), .TAPS(4'b1001), .SHIFTS(1)) dw1 (.clk(clk), .reset_n(reset_n),
    .start(st2), .seed_en(1'b1), .seed_in(4'b0010), .busy(busyw1), .done_tick(donew1), .random_num(rnw1));
  lfsr_rng_param #(.SHIFTS(1)) d1 (.clk(clk), .reset_n(reset_n), .start(st2), .seed_en(1'b1),
    .seed_in(14'h3FFF), .busy(busy1), .done_tick(done1), .random_num(rn1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cyc counts rising edges since reset release, i.e. the entropy counter's expected value
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int unsigned ref_rng(int unsigned seed, int w, int unsigned taps, int n);
    int unsigned v, m;
    int ones;
    m = 1 << w;
    v = seed % m;
    if (FIX && v == m - 1) v = m - 2;
    repeat (n) begin
      ones = 0;
      for (int b = 0; b < w; b++) if (((v & taps) >> b) & 1) ones++;
      v = ((v * 2) % m) + ((ones % 2 == 0) ? 1 : 0);
    end
    return v;
  endfunction

  // entered on an IDLE negedge; leaves on the following IDLE negedge
  task automatic run_req(input bit se, input logic [W-1:0] sd, input int gap);
    int unsigned exp;
    repeat (gap) begin
      start = 0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_hold", random_num, last);
    end
    start = 1; seed_en = se; seed_in = sd;
    exp = ref_rng(se ? sd : cyc, W, 32'h2015, S);
    for (int k = 1; k <= S + 1; k++) begin
      tick();
      start = 1'($urandom); seed_en = 1'($urandom); seed_in = W'($urandom);
      chk("req_busy", busy, 1);
      chk("req_done", done_tick, k == S + 1);
      chk("req_num", random_num, (k == S + 1) ? exp : last);
    end
    last = exp;
    tick();
    chk("post_busy", busy, 0);
    chk("post_done", done_tick, 0);
    chk("post_hold", random_num, last);
  endtask

  initial begin
    #12;
    chk("rst_num", random_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_tick, 0);
    @(negedge clk);
    reset_n = 1;
    cyc = 0;
    st2 = 1;
    tick();
    st2 = 0;
    for (int k = 1; k <= 6; k++) begin
      chk("d4_busy", busy4, k <= 5);
      chk("d4_done", done4, k == 5);
      tick();
    end
    chk("d4_num", rn4, 14'h000B);
    chk("w2_num", rnw2, 4'b0010);
    chk("w1_num", rnw1, 4'b0101);
    chk("d1_num", rn1, FIX ? 14'h3FFC : 14'h3FFF);
    run_req(1'b0, '0, 3);
    for (int i = 0; i < 40; i++)
      run_req(1'($urandom), (i % 9 == 0) ? 14'h3FFF : W'($urandom), $urandom_range(0, 3));
    seed_in = 14'h1234; seed_en = 1; start = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("hold_done", done_tick, k == 15 || k == 31);
      chk("hold_busy", busy, k != 16 && k != 32);
      chk("hold_num", random_num, (k >= 15) ? ref_rng(14'h1234, W, 32'h2015, S) : last);
    end
    start = 0;
    last = ref_rng(14'h1234, W, 32'h2015, S);
    seed_en = 0; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    reset_n = 0;
    #1;
    chk("abort_num", random_num, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done_tick, 0);
    tick();
    reset_n = 1;
    cyc = 0;
    last = 0;
    for (int k = 0; k < S + 3; k++) begin
      tick();
      chk("after_done", done_tick, 0);
      chk("after_busy", busy, 0);
      chk("after_num", random_num, 0);
    end
    run_req(1'b0, '0, 0);
    run_req(1'b0, '0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
